// File: rtl/fpcvt_pkg.sv
// Shared widths and FSM encoding for the FPCVT arbiter slice.
package fpcvt_pkg;
   localparam int D_W = 12;
   localparam int E_W = 3;
   localparam int F_W = 4;

   localparam logic [E_W-1:0] E_MAX = 3'd7;
   localparam logic [F_W-1:0] F_MAX = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      HOLD = 2'd2
   } arb_state_e;
endpackage

// File: rtl/fpcvt_arbiter_if.sv
// Request/result handshake bundle between sample sources, the arbiter and the consumer.
interface fpcvt_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]                 req_valid;
   logic [fpcvt_pkg::D_W*NREQ-1:0]  req_data;
   logic [NREQ-1:0]                 req_ready;
   logic                            out_valid;
   logic                            out_ready;
   logic                            out_s;
   logic [fpcvt_pkg::E_W-1:0]       out_e;
   logic [fpcvt_pkg::F_W-1:0]       out_f;
   logic [IDW-1:0]                  out_id;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_s, out_e, out_f, out_id
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_s, out_e, out_f, out_id
   );
endinterface

// File: rtl/fpcvt.sv
// Combinational 12-bit two's-complement to S/E[2:0]/F[3:0] converter.
module fpcvt
   import fpcvt_pkg::*;
(
   input  logic signed [D_W-1:0] d_i,
   output logic                  s_o,
   output logic [E_W-1:0]        e_o,
   output logic [F_W-1:0]        f_o
);

   logic [D_W-1:0] mag;
   logic [E_W-1:0] e_base;
   logic [F_W-1:0] frac;
   logic           rnd;
   logic [F_W:0]   sum;

   always_comb begin
      s_o = d_i[D_W-1];
      // Most negative input has no positive twin; clamp to the largest magnitude.
      if (d_i == {1'b1, {(D_W-1){1'b0}}})
         mag = {1'b0, {(D_W-1){1'b1}}};
      else if (d_i[D_W-1])
         mag = D_W'(-d_i);
      else
         mag = d_i;

      // E = position of leading one minus 3, so F always spans mag[E+3:E].
      e_base = '0;
      for (int b = F_W; b < D_W; b++) begin
         if (mag[b]) e_base = E_W'(b - 3);
      end

      frac = F_W'(mag >> e_base);
      rnd  = (e_base != '0) && mag[E_W'(e_base - 1'b1)];
      sum  = {1'b0, frac} + {{F_W{1'b0}}, rnd};

      e_o = e_base;
      f_o = sum[F_W-1:0];
      if (sum[F_W]) begin
         if (e_base == E_MAX) begin
            e_o = E_MAX;
            f_o = F_MAX;
         end else begin
            e_o = e_base + 1'b1;
            f_o = {1'b1, {(F_W-1){1'b0}}};
         end
      end
   end

endmodule

// File: rtl/fpcvt_arbiter.sv
// Round-robin sharing of a single fpcvt among NREQ requesters with registered operand/result.
// Optional FPCVT_ARB_SAT_CNT_EN adds sat_count, a saturating count of E=7/F=15 results.
module fpcvt_arbiter
   import fpcvt_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   fpcvt_arbiter_if.slave       bus
`ifdef FPCVT_ARB_SAT_CNT_EN
   ,
   output logic [7:0]           sat_count
`endif
);

   arb_state_e             state_q, state_d;
   logic [IDW-1:0]         rr_q, rr_d;
   logic signed [D_W-1:0]  opnd_q, opnd_d;
   logic [IDW-1:0]         gid_q, gid_d;
   logic                   ov_q, ov_d;
   logic                   s_q, s_d;
   logic [E_W-1:0]         e_q, e_d;
   logic [F_W-1:0]         f_q, f_d;
   logic [IDW-1:0]         id_q, id_d;
   logic [NREQ-1:0]        req_ready_c;
   logic [IDW-1:0]         grant;
   logic                   cvt_s;
   logic [E_W-1:0]         cvt_e;
   logic [F_W-1:0]         cvt_f;

   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [IDW-1:0]  ptr);
      logic [IDW-1:0] g;
      logic           hit;
      int             idx;
      g   = ptr;
      hit = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!hit && v[idx]) begin
            g   = IDW'(idx);
            hit = 1'b1;
         end
      end
      return g;
   endfunction

   fpcvt u_fpcvt (
      .d_i (opnd_q),
      .s_o (cvt_s),
      .e_o (cvt_e),
      .f_o (cvt_f)
   );

   assign grant = rr_pick(bus.req_valid, rr_q);

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      opnd_d      = opnd_q;
      gid_d       = gid_q;
      ov_d        = ov_q;
      s_d         = s_q;
      e_d         = e_q;
      f_d         = f_q;
      id_d        = id_q;
      req_ready_c = '0;

      case (state_q)
         IDLE: begin
            // Grant is combinational; gate with rst so no acceptance is signalled while held in reset.
            if (|bus.req_valid && !rst) begin
               req_ready_c = {{(NREQ-1){1'b0}}, 1'b1} << grant;
               opnd_d      = bus.req_data[int'(grant)*D_W +: D_W];
               gid_d       = grant;
               rr_d        = IDW'((int'(grant) + 1) % NREQ);
               state_d     = CONV;
            end
         end
         CONV: begin
            s_d     = cvt_s;
            e_d     = cvt_e;
            f_d     = cvt_f;
            id_d    = gid_q;
            ov_d    = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         opnd_q  <= '0;
         gid_q   <= '0;
         ov_q    <= 1'b0;
         s_q     <= 1'b0;
         e_q     <= '0;
         f_q     <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         opnd_q  <= opnd_d;
         gid_q   <= gid_d;
         ov_q    <= ov_d;
         s_q     <= s_d;
         e_q     <= e_d;
         f_q     <= f_d;
         id_q    <= id_d;
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.out_valid = ov_q;
   assign bus.out_s     = s_q;
   assign bus.out_e     = e_q;
   assign bus.out_f     = f_q;
   assign bus.out_id    = id_q;

`ifdef FPCVT_ARB_SAT_CNT_EN
   logic [7:0] sat_q, sat_d;

   always_comb begin
      sat_d = sat_q;
      if (state_q == CONV && cvt_e == E_MAX && cvt_f == F_MAX && sat_q != 8'hFF)
         sat_d = sat_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sat_q <= '0;
      else     sat_q <= sat_d;
   end

   assign sat_count = sat_q;
`endif

endmodule

// File: tb/tb_fpcvt_arbiter.sv
// Directed + randomized bench for fpcvt_arbiter against a transaction-level reference model.
module tb_fpcvt_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fpcvt_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef FPCVT_ARB_SAT_CNT_EN
   logic [7:0] sat_count;
   int         sat_m = 0;
`endif

   fpcvt_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FPCVT_ARB_SAT_CNT_EN
      ,
      .sat_count (sat_count)
`endif
   );

   int          vectors = 0;
   int          miscompares = 0;
   int          rr_m = 0;
   logic [3:0]  rv;
   logic [11:0] rd [4];
   int          last_g;
   int          ftab [5] = '{11, 11, 12, 12, 11};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      bus.req_valid = rv;
      bus.req_data  = {rd[3], rd[2], rd[1], rd[0]};
   endtask

   function automatic int pick(input logic [3:0] v, input int rr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic void ref_cvt(input logic [11:0] d, output logic s, output int e, output int f);
      int v, mag, lz;
      v   = int'($signed(d));
      s   = (v < 0);
      mag = (v < 0) ? -v : v;
      if (mag > 2047) mag = 2047;
      lz = 0;
      while (lz < 12 && mag < (1 << (11 - lz))) lz++;
      e = 8 - lz;
      if (e < 0) e = 0;
      if (e > 7) e = 7;
      f = (e == 0) ? mag : ((mag + (1 << (e - 1))) >> e);
      if (f > 15) begin f = 8; e++; end
      if (e > 7) begin e = 7; f = 15; end
   endfunction

   // Entered just after a rising edge with the FSM idle; returns just after the edge that leaves HOLD.
   task automatic serve(input int hold, input bit wiggle);
      int   g, ee, ef;
      logic es;
      g = pick(rv, rr_m);
      @(negedge clk);
      chk("req_ready_idle", bus.req_ready, (g < 0) ? 0 : (1 << g));
      chk("out_valid_idle", bus.out_valid, 0);
      if (g < 0) begin
         @(posedge clk); #1;
         return;
      end
      ref_cvt(rd[g], es, ee, ef);
      rr_m   = (g + 1) % NREQ;
      last_g = g;
      @(posedge clk); #1;
      if (wiggle) begin rv = 4'($urandom); apply(); end
      @(negedge clk);
      chk("req_ready_conv", bus.req_ready, 0);
      chk("out_valid_conv", bus.out_valid, 0);
      @(posedge clk); #1;
      bus.out_ready = (hold == 0);
`ifdef FPCVT_ARB_SAT_CNT_EN
      if (ee == 7 && ef == 15 && sat_m < 255) sat_m++;
`endif
      for (int i = 0; i <= hold; i++) begin
         @(negedge clk);
         chk("out_valid_hold", bus.out_valid, 1);
         chk("out_s", bus.out_s, es);
         chk("out_e", bus.out_e, ee);
         chk("out_f", bus.out_f, ef);
         chk("out_id", bus.out_id, g);
         chk("req_ready_hold", bus.req_ready, 0);
`ifdef FPCVT_ARB_SAT_CNT_EN
         chk("sat_count", sat_count, sat_m);
`endif
         @(posedge clk); #1;
         if (i + 1 == hold) bus.out_ready = 1'b1;
      end
      bus.out_ready = 1'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus.out_ready = 1'b0;
      rv = 4'hF;
      for (int i = 0; i < 4; i++) rd[i] = 12'h000;
      apply();
      repeat (2) @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_s", bus.out_s, 0);
      chk("rst_out_e", bus.out_e, 0);
      chk("rst_out_f", bus.out_f, 0);
      chk("rst_out_id", bus.out_id, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      rv = 4'h0;
      apply();
      rr_m = 0;

      // Idle for 20 cycles with no requests.
      for (int i = 0; i < 20; i++) begin
         bus.out_ready = 1'($urandom);
         @(negedge clk);
         chk("idle_req_ready", bus.req_ready, 0);
         chk("idle_out_valid", bus.out_valid, 0);
      end
      @(posedge clk); #1;

      // All four held valid: grants rotate 0,1,2,3,0.
      rv = 4'hF;
      rd[0] = 12'h02C; rd[1] = 12'h02D; rd[2] = 12'h02E; rd[3] = 12'h02F;
      apply();
      for (int k = 0; k < 5; k++) begin
         serve(0, 0);
         chk("t3_grant", last_g, k % 4);
         chk("t3_f", bus.out_f, ftab[k]);
         chk("t3_e", bus.out_e, 2);
         chk("t3_s", bus.out_s, 0);
      end

      rv = 4'b0001; rd[0] = 12'h0AA; apply();
      serve(0, 0);
      chk("t1_s", bus.out_s, 0);
      chk("t1_e", bus.out_e, 4);
      chk("t1_f", bus.out_f, 11);
      chk("t1_id", bus.out_id, 0);

      rv = 4'b0110; rd[1] = 12'hFFF; rd[2] = 12'h800; apply();
      serve(0, 0);
      chk("t2a_id", bus.out_id, 1);
      chk("t2a_s", bus.out_s, 1);
      chk("t2a_e", bus.out_e, 0);
      chk("t2a_f", bus.out_f, 1);
      rv = 4'b0100; apply();
      serve(0, 0);
      chk("t2b_id", bus.out_id, 2);
      chk("t2b_s", bus.out_s, 1);
      chk("t2b_e", bus.out_e, 7);
      chk("t2b_f", bus.out_f, 15);
`ifdef FPCVT_ARB_SAT_CNT_EN
      chk("t2b_sat", sat_count, 1);
`endif

      // Consumer stalls for 10 cycles.
      rv = 4'b1000; rd[3] = 12'h123; apply();
      serve(10, 0);
      rv = 4'b0000; apply();
      serve(0, 0);

      // Reset during CONV.
      rv = 4'b1001; rd[0] = 12'h0AA; apply();
      @(negedge clk);
      chk("t5a_grant", bus.req_ready, 4'b0001);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("t5a_req_ready", bus.req_ready, 0);
      chk("t5a_out_valid", bus.out_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      rr_m = 0;
`ifdef FPCVT_ARB_SAT_CNT_EN
      sat_m = 0;
`endif

      // Reset during HOLD; pointer must restart at zero.
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("t5b_grant", bus.req_ready, 4'b0001);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5b_hold_valid", bus.out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5b_out_valid", bus.out_valid, 0);
      chk("t5b_req_ready", bus.req_ready, 0);
      chk("t5b_out_e", bus.out_e, 0);
      chk("t5b_out_f", bus.out_f, 0);
      chk("t5b_out_id", bus.out_id, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      rr_m = 0;
`ifdef FPCVT_ARB_SAT_CNT_EN
      sat_m = 0;
      chk("t5b_sat", sat_count, 0);
`endif
      serve(0, 0);
      chk("t5_first_after_rst", last_g, 0);

      // Randomized traffic with boundary operands mixed in.
      for (int r = 0; r < 80; r++) begin
         rv = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 5))
               0:       rd[i] = 12'h800;
               1:       rd[i] = 12'h7FF;
               2:       rd[i] = 12'h000;
               default: rd[i] = 12'($urandom);
            endcase
         end
         apply();
         bus.out_ready = 1'($urandom);
         serve($urandom_range(0, 3), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
